// File: rtl/lcv_mul_acc_pkg.sv
// lcv_mul_acc_pkg
// Shared helpers for the pipelined signed multiply-accumulate:
//   - stage_p_flags_t : control payload travelling with the stage-P product
//   - add_ovf         : signed-overflow detect for a two's-complement add
//   - sat_limit_bit   : one bit of the max/min signed value of a given width
// All widths are supplied by the caller; nothing here fixes a datapath size.
package lcv_mul_acc_pkg;

    // Per-beat framing flags registered next to the stage-P product.
    typedef struct packed {
        logic first;
        logic last;
    } stage_p_flags_t;

    // Overflow of s = a + b: both operands share a sign that the sum lost.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

    // Bit idx of the saturation bound of a w-bit signed value.
    // neg=1 gives the minimum (1000..0), neg=0 the maximum (0111..1).
    function automatic logic sat_limit_bit(input logic neg, input int idx,
                                           input int w);
        return (idx == w - 1) ? neg : ~neg;
    endfunction

endpackage

// File: rtl/lcv_acc_add_sat.sv
// lcv_acc_add_sat
// Combinational ACC_WIDTH signed add used by the accumulator stage.
// Optional feature macro: LCV_MUL_ACC_PIPE_SAT_EN
//   defined   -> on overflow the sum clamps to the signed max/min
//   undefined -> two's-complement wrap, no clamp logic
// Ports:
//   lhs, rhs : signed addends
//   sum      : signed result (wrapped or saturated)
//   ovf      : signed overflow of the raw add
module lcv_acc_add_sat #(
    parameter int ACC_WIDTH = 48
) (
    input  logic signed [ACC_WIDTH-1:0] lhs,
    input  logic signed [ACC_WIDTH-1:0] rhs,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        ovf
);
    import lcv_mul_acc_pkg::*;

    logic signed [ACC_WIDTH-1:0] raw;

    assign raw = lhs + rhs;
    assign ovf = add_ovf(lhs[ACC_WIDTH-1], rhs[ACC_WIDTH-1], raw[ACC_WIDTH-1]);

`ifdef LCV_MUL_ACC_PIPE_SAT_EN
    logic signed [ACC_WIDTH-1:0] sat_val;

    // On overflow both operands carry the same sign, so lhs picks the bound.
    always_comb begin
        sat_val = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            sat_val[i] = sat_limit_bit(lhs[ACC_WIDTH-1], i, ACC_WIDTH);
        end
    end

    assign sum = ovf ? sat_val : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/lcv_mul_acc_pipe.sv
// lcv_mul_acc_pipe
// Pipelined signed multiply-accumulate with valid/ready on both sides.
// Each accepted beat forms a*b+c and folds it into a running sum; a beat
// flagged last publishes the sum downstream two cycles after acceptance.
// Optional feature macro: LCV_MUL_ACC_PIPE_SAT_EN (saturating accumulate).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   inp_valid/inp_ready  : input handshake
//   inp_a, inp_b, inp_c  : signed multiplicand, multiplier, addend
//   inp_first, inp_last  : open a new sum / close and emit the sum
//   outp_valid/outp_ready: output handshake
//   outp_acc, outp_ovf   : result and sticky overflow for that result
module lcv_mul_acc_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int C_WIDTH   = 33,
    parameter int ACC_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inp_valid,
    output logic                        inp_ready,
    input  logic signed [A_WIDTH-1:0]   inp_a,
    input  logic signed [B_WIDTH-1:0]   inp_b,
    input  logic signed [C_WIDTH-1:0]   inp_c,
    input  logic                        inp_first,
    input  logic                        inp_last,
    output logic                        outp_valid,
    input  logic                        outp_ready,
    output logic signed [ACC_WIDTH-1:0] outp_acc,
    output logic                        outp_ovf
);
    import lcv_mul_acc_pkg::*;

    if ((ACC_WIDTH < A_WIDTH + B_WIDTH + 1) || (ACC_WIDTH < C_WIDTH + 1)) begin : g_width_check
        $error("lcv_mul_acc_pipe: ACC_WIDTH too narrow for a*b+c");
    end

    // Whole pipe moves together; it only stalls behind an unconsumed result.
    logic advance;
    assign advance   = !outp_valid || outp_ready;
    assign inp_ready = advance;

    logic signed [ACC_WIDTH-1:0] a_ext, b_ext, c_ext, prod_nxt;
    assign a_ext    = {{(ACC_WIDTH-A_WIDTH){inp_a[A_WIDTH-1]}}, inp_a};
    assign b_ext    = {{(ACC_WIDTH-B_WIDTH){inp_b[B_WIDTH-1]}}, inp_b};
    assign c_ext    = {{(ACC_WIDTH-C_WIDTH){inp_c[C_WIDTH-1]}}, inp_c};
    assign prod_nxt = a_ext * b_ext + c_ext;

    // ---- stage P: product + addend ----
    logic                        vld_p1;
    logic signed [ACC_WIDTH-1:0] prod_p1;
    stage_p_flags_t              flags_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= inp_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            prod_p1        <= prod_nxt;
            flags_p1.first <= inp_first;
            flags_p1.last  <= inp_last;
        end
    end

    // ---- stage A: accumulate and publish ----
    logic signed [ACC_WIDTH-1:0] acc_p2, sum_add, acc_nxt;
    logic                        ovf_p2, open_p2, add_ovf_w, ovf_nxt, start, take_p1;

    lcv_acc_add_sat #(.ACC_WIDTH(ACC_WIDTH)) u_add (
        .lhs (acc_p2),
        .rhs (prod_p1),
        .sum (sum_add),
        .ovf (add_ovf_w)
    );

    // No open sum (after reset or a last beat) behaves as an implicit first.
    assign start   = flags_p1.first || !open_p2;
    assign acc_nxt = start ? prod_p1 : sum_add;
    assign ovf_nxt = start ? 1'b0 : (ovf_p2 || add_ovf_w);
    assign take_p1 = advance && vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p2     <= '0;
            ovf_p2     <= 1'b0;
            open_p2    <= 1'b0;
            outp_valid <= 1'b0;
            outp_acc   <= '0;
            outp_ovf   <= 1'b0;
        end else begin
            if (take_p1) begin
                acc_p2  <= acc_nxt;
                ovf_p2  <= ovf_nxt;
                open_p2 <= !flags_p1.last;
            end
            // A completing last beat overrides the clear, so results can
            // leave back-to-back.
            if (take_p1 && flags_p1.last) begin
                outp_valid <= 1'b1;
                outp_acc   <= acc_nxt;
                outp_ovf   <= ovf_nxt;
            end else if (outp_ready) begin
                outp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
module tb_lcv_mul_acc_pipe;

    localparam int AW = 16;
    localparam int BW = 16;
    localparam int CW = 32;
    localparam int ACCW = 33;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   inp_valid = 1'b0;
    logic                   inp_ready;
    logic signed [AW-1:0]   inp_a = '0;
    logic signed [BW-1:0]   inp_b = '0;
    logic signed [CW-1:0]   inp_c = '0;
    logic                   inp_first = 1'b0;
    logic                   inp_last = 1'b0;
    logic                   outp_valid;
    logic                   outp_ready = 1'b1;
    logic signed [ACCW-1:0] outp_acc;
    logic                   outp_ovf;

    int n_pass = 0;
    int n_total = 0;
    longint ovf_exp_acc;

    lcv_mul_acc_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .C_WIDTH(CW), .ACC_WIDTH(ACCW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inp_valid  (inp_valid),
        .inp_ready  (inp_ready),
        .inp_a      (inp_a),
        .inp_b      (inp_b),
        .inp_c      (inp_c),
        .inp_first  (inp_first),
        .inp_last   (inp_last),
        .outp_valid (outp_valid),
        .outp_ready (outp_ready),
        .outp_acc   (outp_acc),
        .outp_ovf   (outp_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int a, input int b, input int c,
                        input bit f, input bit l);
        int n;
        n = 0;
        inp_a = a[AW-1:0];
        inp_b = b[BW-1:0];
        inp_c = c[CW-1:0];
        inp_first = f;
        inp_last = l;
        inp_valid = 1'b1;
        while (!inp_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) check("send_ready_timeout", 64'(inp_ready), 64'sd1);
        @(posedge clk); #1;
        inp_valid = 1'b0;
        inp_first = 1'b0;
        inp_last = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
        ovf_exp_acc = 64'sd4294967295;
`else
        ovf_exp_acc = -64'sd3221553147;
`endif
        // reset state
        #1 rst = 1'b1;
        #2;
        check("rst_valid", 64'(outp_valid), 0);
        check("rst_acc", 64'(outp_acc), 0);
        check("rst_ovf", 64'(outp_ovf), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 64'(inp_ready), 1);

        // single beat 3*-4+5, exact two-cycle latency
        send(3, -4, 5, 1'b1, 1'b1);
        check("single_early", 64'(outp_valid), 0);
        tick();
        check("single_valid", 64'(outp_valid), 1);
        check("single_acc", 64'(outp_acc), -7);
        check("single_ovf", 64'(outp_ovf), 0);
        tick();
        check("single_clear", 64'(outp_valid), 0);

        // dot product, implicit first
        send(1, 2, 0, 1'b0, 1'b0);
        check("dot_b1_novalid", 64'(outp_valid), 0);
        send(3, 4, 0, 1'b0, 1'b0);
        check("dot_b2_novalid", 64'(outp_valid), 0);
        send(5, 6, 0, 1'b0, 1'b0);
        check("dot_b3_novalid", 64'(outp_valid), 0);
        send(7, 8, 0, 1'b0, 1'b1);
        check("dot_b4_novalid", 64'(outp_valid), 0);
        tick();
        check("dot_valid", 64'(outp_valid), 1);
        check("dot_acc", 64'(outp_acc), 100);
        tick();
        check("dot_clear", 64'(outp_valid), 0);

        // backpressure: result 7 held, second result 20 after release
        outp_ready = 1'b0;
        send(2, 3, 1, 1'b1, 1'b1);
        send(4, 5, 0, 1'b0, 1'b0);
        check("bp_ready_low", 64'(inp_ready), 0);
        check("bp_valid", 64'(outp_valid), 1);
        check("bp_acc1", 64'(outp_acc), 7);
        inp_a = 16'sd1;
        inp_b = 16'sd1;
        inp_c = -32'sd1;
        inp_last = 1'b1;
        inp_valid = 1'b1;
        repeat (5) tick();
        check("bp_hold_valid", 64'(outp_valid), 1);
        check("bp_hold_acc", 64'(outp_acc), 7);
        check("bp_hold_ready", 64'(inp_ready), 0);
        outp_ready = 1'b1;
        #1;
        check("bp_ready_back", 64'(inp_ready), 1);
        tick();
        inp_valid = 1'b0;
        inp_last = 1'b0;
        check("bp_mid_novalid", 64'(outp_valid), 0);
        tick();
        check("bp_valid2", 64'(outp_valid), 1);
        check("bp_acc2", 64'(outp_acc), 20);
        tick();

        // first mid-stream drops partial sum
        send(10, 1, 0, 1'b0, 1'b0);
        send(20, 1, 0, 1'b0, 1'b0);
        send(1, 1, 0, 1'b1, 1'b1);
        tick();
        check("midfirst_valid", 64'(outp_valid), 1);
        check("midfirst_acc", 64'(outp_acc), 1);
        tick();

        // overflow: five beats of 0x7FFF*0x7FFF exceed 2^32-1
        repeat (4) send(32767, 32767, 0, 1'b0, 1'b0);
        send(32767, 32767, 0, 1'b0, 1'b1);
        tick();
        check("ovf_valid", 64'(outp_valid), 1);
        check("ovf_acc", 64'(outp_acc), ovf_exp_acc);
        check("ovf_flag", 64'(outp_ovf), 1);
        tick();
        send(-3, 5, -1, 1'b1, 1'b1);
        tick();
        check("ovf_next_acc", 64'(outp_acc), -16);
        check("ovf_next_flag", 64'(outp_ovf), 0);
        tick();

        // asynchronous reset with a held result and an open sum
        outp_ready = 1'b0;
        send(6, 6, 0, 1'b1, 1'b1);
        send(100, 100, 0, 1'b0, 1'b0);
        check("ar_pre_acc", 64'(outp_acc), 36);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 64'(outp_valid), 0);
        check("ar_acc", 64'(outp_acc), 0);
        check("ar_ovf", 64'(outp_ovf), 0);
        check("ar_ready", 64'(inp_ready), 1);
        @(posedge clk);
        #3 rst = 1'b0;
        outp_ready = 1'b1;
        tick();
        send(2, 2, 0, 1'b0, 1'b1);
        tick();
        check("ar_after_valid", 64'(outp_valid), 1);
        check("ar_after_acc", 64'(outp_acc), 4);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
